// File: rtl/christmas_tree_maligayang_pasko.sv
// Holiday light show: eight tree lights driven by one of four animation
// patterns, plus the greeting "MALIGAYANG PASKO" streamed one ASCII character
// per animation step on the bidirectional port. A selectable prescaler paces
// the animation, and a pause input freezes it.
module christmas_tree_maligayang_pasko (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Greeting ROM, one character per animation step.
    function automatic logic [7:0] greeting_char(input logic [3:0] idx);
        logic [7:0] ch;
        case (idx)
            4'd0:    ch = 8'h4D; // M
            4'd1:    ch = 8'h41; // A
            4'd2:    ch = 8'h4C; // L
            4'd3:    ch = 8'h49; // I
            4'd4:    ch = 8'h47; // G
            4'd5:    ch = 8'h41; // A
            4'd6:    ch = 8'h59; // Y
            4'd7:    ch = 8'h41; // A
            4'd8:    ch = 8'h4E; // N
            4'd9:    ch = 8'h47; // G
            4'd10:   ch = 8'h20; // space
            4'd11:   ch = 8'h50; // P
            4'd12:   ch = 8'h41; // A
            4'd13:   ch = 8'h53; // S
            4'd14:   ch = 8'h4B; // K
            4'd15:   ch = 8'h4F; // O
            default: ch = 8'h20;
        endcase
        return ch;
    endfunction

    // Maximal-length Fibonacci step; the all-zero state is never reached
    // from a non-zero seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    logic        pause_s;
    logic [1:0]  mode_s;
    logic [1:0]  speed_s;
    logic [15:0] period_m1_s;
    logic        tick_s;
    logic        unused_s;

    logic [15:0] cnt_r;
    logic [7:0]  lfsr_r;
    logic [7:0]  chase_r;
    logic        phase_r;
    logic [3:0]  msg_idx_r;

    assign pause_s  = ui_in[0];
    assign mode_s   = ui_in[2:1];
    assign speed_s  = ui_in[4:3];
    assign unused_s = ^{ena, uio_in, ui_in[7:5]};

    // Prescaler terminal count (period minus one) for the selected speed.
    always_comb begin
        period_m1_s = 16'd15;
        case (speed_s)
            2'd0:    period_m1_s = 16'd15;
            2'd1:    period_m1_s = 16'd255;
            2'd2:    period_m1_s = 16'd4095;
            2'd3:    period_m1_s = 16'hFFFF;
            default: period_m1_s = 16'd15;
        endcase
    end

    // Using >= lets a speed increase mid-count fire on the next edge instead
    // of waiting for the 16-bit counter to wrap.
    assign tick_s = (cnt_r >= period_m1_s);

    // Prescaler and animation state; reset wins over pause, pause over tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= 16'd0;
            lfsr_r    <= 8'h01;
            chase_r   <= 8'h01;
            phase_r   <= 1'b0;
            msg_idx_r <= 4'd0;
        end else if (!pause_s) begin
            if (tick_s) begin
                cnt_r     <= 16'd0;
                lfsr_r    <= lfsr_next(lfsr_r);
                chase_r   <= {chase_r[6:0], chase_r[7]};
                phase_r   <= ~phase_r;
                msg_idx_r <= msg_idx_r + 4'd1;
            end else begin
                cnt_r     <= cnt_r + 16'd1;
            end
        end
    end

    // Light pattern mux; follows the select with no added latency.
    always_comb begin
        uo_out = 8'hFF;
        case (mode_s)
            2'd0:    uo_out = lfsr_r;
            2'd1:    uo_out = chase_r;
            2'd2:    uo_out = phase_r ? 8'hAA : 8'h55;
            2'd3:    uo_out = 8'hFF;
            default: uo_out = 8'hFF;
        endcase
    end

    assign uio_out = greeting_char(msg_idx_r);
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_christmas_tree_maligayang_pasko.sv
// Scoreboard bench: the driver pushes the expected outputs for every cycle
// from an abstract model (step count n, elapsed unpaused cycles), and a
// monitor on the falling edge pops and compares.
module tb_christmas_tree_maligayang_pasko;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    christmas_tree_maligayang_pasko dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    passed = 0;
    string greeting = "MALIGAYANG PASKO";
    logic [7:0] lfsr_seq[255];

    // Abstract model: number of advances since reset and unpaused cycles
    // spent in the current period.
    int n = 0;
    int elapsed = 0;

    function automatic exp_t expect_for(input logic [1:0] m);
        exp_t e;
        case (m)
            2'd0:    e.uo = lfsr_seq[n % 255];
            2'd1:    e.uo = 8'(1 << (n % 8));
            2'd2:    e.uo = (n % 2 == 1) ? 8'hAA : 8'h55;
            default: e.uo = 8'hFF;
        endcase
        e.uio = greeting[n % 16];
        e.oe  = 8'hFF;
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // One clock cycle: drive inputs, push expectation, take the edge, update model.
    task automatic run_cycle(input logic r, input logic p, input logic [1:0] m, input logic [1:0] s);
        int period;
        rst_n  = r;
        ui_in  = {3'($urandom), s, m, p};
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        q.push_back(expect_for(m));
        @(posedge clk);
        period = 16 << (4 * int'(s));
        if (!r) begin
            n = 0;
            elapsed = 0;
        end else if (!p) begin
            if (elapsed >= period - 1) begin
                elapsed = 0;
                n++;
            end else begin
                elapsed++;
            end
        end
        #1;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("uo_out",  uo_out,  e.uo);
            chk("uio_out", uio_out, e.uio);
            chk("uio_oe",  uio_oe,  e.oe);
        end
    end

    initial begin
        logic [7:0] v;
        logic [1:0] m;
        logic [1:0] s;
        int len;

        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            lfsr_seq[i] = v;
            v = {v[6:0], ^(v & 8'b1011_1000)};
        end

        rst_n = 1'b0; ui_in = 8'h00; uio_in = 8'h00; ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values in each mode.
        run_cycle(1'b0, 1'b0, 2'd0, 2'd0);
        run_cycle(1'b0, 1'b0, 2'd0, 2'd0);
        run_cycle(1'b0, 1'b1, 2'd2, 2'd0);
        run_cycle(1'b0, 1'b0, 2'd3, 2'd0);
        run_cycle(1'b0, 1'b0, 2'd1, 2'd0);

        // LFSR twinkle at speed 0.
        for (int i = 0; i < 80; i++) run_cycle(1'b1, 1'b0, 2'd0, 2'd0);

        // Chase and full greeting wrap.
        run_cycle(1'b0, 1'b0, 2'd1, 2'd0);
        for (int i = 0; i < 16 * 17 + 3; i++) run_cycle(1'b1, 1'b0, 2'd1, 2'd0);

        // Alternating pattern with mid-period switch to all-on and back.
        for (int i = 0; i < 37; i++) run_cycle(1'b1, 1'b0, 2'd2, 2'd0);
        for (int i = 0; i < 5;  i++) run_cycle(1'b1, 1'b0, 2'd3, 2'd0);
        for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b0, 2'd2, 2'd0);

        // Pause for 100 cycles mid-period.
        for (int i = 0; i < 7;   i++) run_cycle(1'b1, 1'b0, 2'd1, 2'd0);
        for (int i = 0; i < 100; i++) run_cycle(1'b1, 1'b1, 2'd1, 2'd0);
        for (int i = 0; i < 40;  i++) run_cycle(1'b1, 1'b0, 2'd1, 2'd0);

        // Speed 1 past cnt 15, then drop to speed 0; then reset mid-period.
        run_cycle(1'b0, 1'b0, 2'd1, 2'd1);
        for (int i = 0; i < 300; i++) run_cycle(1'b1, 1'b0, 2'd1, 2'd1);
        for (int i = 0; i < 40;  i++) run_cycle(1'b1, 1'b0, 2'd1, 2'd0);
        for (int i = 0; i < 9;   i++) run_cycle(1'b1, 1'b0, 2'd0, 2'd0);
        run_cycle(1'b0, 1'b1, 2'd0, 2'd0);
        for (int i = 0; i < 20;  i++) run_cycle(1'b1, 1'b0, 2'd0, 2'd0);

        // Randomized segments.
        for (int seg = 0; seg < 40; seg++) begin
            m   = 2'($urandom);
            s   = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
            len = $urandom_range(20, 150);
            for (int i = 0; i < len; i++)
                run_cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0), m, s);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
